alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_alu_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler -- two-requester round-robin front end for a multi-cycle ALU.
//
// Purpose:
//   Accepts one command at a time from two requesters. The command is either
//   answered directly (opcode 3'b000) or issued to the ALU. In the ALU case the
//   block waits for alu_done and returns exactly one response pulse, or gives
//   up after TIMEOUT busy cycles.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   reqN_valid / reqN_ready  command handshake, N = 0,1 (ready is combinational)
//   reqN_a, reqN_b, reqN_op  operands and opcode of requester N
//   alu_start                ALU start strobe, held high while waiting
//   alu_a, alu_b, alu_op     command driven to the ALU
//   alu_done, alu_result     ALU completion and result
//   rsp_valid                one-cycle response pulse
//   rsp_id                   index of the requester that was served
//   rsp_result, rsp_err      response data, timeout flag (both held between pulses)
//   busy                     high whenever the scheduler is not idle
module alu_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req1_op,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic            last_grant_r;  // requester granted most recently (1 after reset => req0 first)
  logic            cmd_id_r;      // requester owning the command in flight
  logic [CW-1:0]   cnt_r;         // BUSY cycle counter, 0 on entry

  logic            grant_valid_s;
  logic            grant_id_s;
  logic [7:0]      sel_a_s;
  logic [7:0]      sel_b_s;
  logic [2:0]      sel_op_s;
  logic            accept_s;

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_r;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    if (grant_id_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
  end

  // Ready is gated by reset_n so nothing looks accepted while reset is held.
  assign accept_s   = reset_n && (state_r == IDLE) && grant_valid_s;
  assign req0_ready = accept_s && (grant_id_s == 1'b0);
  assign req1_ready = accept_s && (grant_id_s == 1'b1);

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cmd_id_r     <= 1'b0;
      cnt_r        <= '0;
      alu_start    <= 1'b0;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_op       <= 3'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 16'd0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (grant_valid_s) begin
            last_grant_r <= grant_id_s;
            cmd_id_r     <= grant_id_s;
            busy         <= 1'b1;
            if (sel_op_s == 3'b000) begin
              // No-op: answer straight away without touching the ALU.
              state_r    <= RESP;
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_id_s;
              rsp_result <= 16'd0;
              rsp_err    <= 1'b0;
            end else begin
              state_r   <= BUSY;
              alu_start <= 1'b1;
              alu_a     <= sel_a_s;
              alu_b     <= sel_b_s;
              alu_op    <= sel_op_s;
              cnt_r     <= '0;
            end
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CNT_ONE;
          // alu_done in the first BUSY cycle may belong to the previous command.
          // Done is tested first so it wins over a coincident timeout.
          if (alu_done && (cnt_r != '0)) begin
            state_r    <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cmd_id_r;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else if (cnt_r == LAST_CNT) begin
            state_r    <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cmd_id_r;
            rsp_result <= 16'd0;
            rsp_err    <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          alu_start <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed table, reset-abort sequence,
// then randomized commands checked against a transaction-level reference model.
module tb_alu_scheduler;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        alu_start;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [15:0] rsp_result;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_mode = 0;   // 0 normal, 1 never done, 2 stale done in first cycle too, 3 done only at TIMEOUT-1
  int model_last;      // reference model's last-granted requester
  int st_cnt = 0;      // cycles alu_start has been high before the current one

  always #5 clk = ~clk;

  alu_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  // Arithmetic meaning of each opcode (shared by the ALU stand-in and the model).
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return {8'd0, a} + {8'd0, b};
      3'd2:    return {8'd0, a & b};
      3'd3:    return {8'd0, a ^ b};
      3'd0:    return 16'd0;
      default: return {8'd0, a} * {8'd0, b};
    endcase
  endfunction

  // ALU stand-in: done after 2 start cycles for 001..011, 5 for 1xx.
  always @(posedge clk) begin
    if (!alu_start) st_cnt <= 0;
    else            st_cnt <= st_cnt + 1;
  end

  int lat;
  assign lat = alu_op[2] ? 5 : 2;
  assign alu_done = alu_start && (((done_mode == 0) && (st_cnt == lat - 1)) ||
                                  ((done_mode == 2) && ((st_cnt == 0) || (st_cnt == lat - 1))) ||
                                  ((done_mode == 3) && (st_cnt == TIMEOUT - 1)));
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, req0_ready, req1_ready, alu_start, alu_a, alu_b, alu_op,
            rsp_valid, rsp_id, rsp_result, rsp_err, busy};
  endfunction

  // One command: entered just after a falling edge, returns just after a falling edge in IDLE.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input int mode, input logic eid, input logic [15:0] eres,
                        input logic eerr, input int estarts);
    int k;
    int starts;
    bit got;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    done_mode = mode;
    #1;
    k = 0;
    while (!(req0_ready || req1_ready) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!(req0_ready || req1_ready)) begin
      chk("ready_wait_expired", 64'd0, 64'd1);
      return;
    end
    chk("grant_id", {63'd0, req1_ready}, {63'd0, eid});
    chk("single_grant", {63'd0, req0_ready & req1_ready}, 64'd0);
    @(posedge clk);
    starts = 0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (alu_start) starts++;
      if (rsp_valid) begin
        got = 1'b1;
        chk("rsp_latency", 64'(c), 64'(estarts + 1));
      end
    end
    if (!got) begin
      chk("rsp_wait_expired", 64'd0, 64'd1);
      return;
    end
    chk("rsp_id", {63'd0, rsp_id}, {63'd0, eid});
    chk("rsp_result", {48'd0, rsp_result}, {48'd0, eres});
    chk("rsp_err", {63'd0, rsp_err}, {63'd0, eerr});
    chk("start_cycles", 64'(starts), 64'(estarts));
    chk("start_low_in_resp", {63'd0, alu_start}, 64'd0);
    @(negedge clk);
    chk("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
    chk("rsp_result_held", {48'd0, rsp_result}, {48'd0, eres});
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic v0; logic v1;
    logic [2:0] op0; logic [7:0] a0; logic [7:0] b0;
    logic [2:0] op1; logic [7:0] a1; logic [7:0] b1;
    int mode;
    logic eid; logic [15:0] eres; logic eerr; int estarts;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit any_rsp;
    // Directed vectors; expectations worked out by hand from the arbitration rules.
    vecs[0]  = '{1'b1, 1'b0, 3'd1, 8'h05, 8'h03, 3'd0, 8'h00, 8'h00, 0, 1'b0, 16'h0008, 1'b0, 2};
    vecs[1]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'd4, 8'hFF, 8'hFF, 0, 1'b1, 16'hFE01, 1'b0, 5};
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 8'hF0, 8'h3C, 3'd2, 8'hF0, 8'h3C, 0, 1'b0, 16'h0030, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b1, 3'd2, 8'hF0, 8'h3C, 3'd2, 8'hF0, 8'h3C, 0, 1'b1, 16'h0030, 1'b0, 2};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 8'hF0, 8'h3C, 3'd2, 8'hF0, 8'h3C, 0, 1'b0, 16'h0030, 1'b0, 2};
    vecs[5]  = '{1'b1, 1'b1, 3'd2, 8'hF0, 8'h3C, 3'd2, 8'hF0, 8'h3C, 0, 1'b1, 16'h0030, 1'b0, 2};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 8'h77, 8'h66, 3'd0, 8'h00, 8'h00, 0, 1'b0, 16'h0000, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 8'h05, 8'h03, 3'd0, 8'h00, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 15};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'd7, 8'h12, 8'h34, 0, 1'b1, 16'h03A8, 1'b0, 5};
    vecs[9]  = '{1'b1, 1'b0, 3'd3, 8'h3C, 8'h0F, 3'd0, 8'h00, 8'h00, 2, 1'b0, 16'h0033, 1'b0, 2};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'd1, 8'h01, 8'h02, 3, 1'b1, 16'h0003, 1'b0, 15};

    // Reset with both requesters asserting: nothing may be accepted or driven.
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h33; req1_b = 8'h44;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", all_outs(), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].v0, vecs[i].v1, vecs[i].op0, vecs[i].a0, vecs[i].b0,
             vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].mode,
             vecs[i].eid, vecs[i].eres, vecs[i].eerr, vecs[i].estarts);
    end

    // Reset in the middle of a multiply aborts it with no response.
    done_mode = 0;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h10; req0_b = 8'h10;
    #1;
    chk("abort_cmd_ready", {63'd0, req0_ready}, 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("abort_cmd_busy", {62'd0, busy, alu_start}, 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero", all_outs(), 64'd0);
    reset_n = 1'b1;
    any_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) any_rsp = 1'b1;
    end
    chk("abort_no_rsp", {63'd0, any_rsp}, 64'd0);
    do_txn(1'b1, 1'b0, 3'd3, 8'hAA, 8'h0F, 3'd0, 8'h00, 8'h00, 0, 1'b0, 16'h00A5, 1'b0, 2);

    // Randomized commands against a transaction-level model.
    model_last = 0;
    for (int t = 0; t < 40; t++) begin
      logic v0, v1, win, eerr;
      logic [2:0] op0, op1, op;
      logic [7:0] a0, b0, a1, b1, a, b;
      logic [15:0] eres;
      int mode, r, est;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
      op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      if (v0 && v1) win = (model_last == 0) ? 1'b1 : 1'b0;
      else          win = v0 ? 1'b0 : 1'b1;
      model_last = win ? 1 : 0;
      op = win ? op1 : op0;
      a  = win ? a1 : a0;
      b  = win ? b1 : b0;
      if (op == 3'd0) begin
        eres = 16'd0; eerr = 1'b0; est = 0;
      end else if (mode == 1) begin
        eres = 16'd0; eerr = 1'b1; est = TIMEOUT;
      end else begin
        eres = alu_fn(op, a, b); eerr = 1'b0; est = op[2] ? 5 : 2;
      end
      do_txn(v0, v1, op0, a0, b0, op1, a1, b1, mode, win, eres, eerr, est);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
